// File: rtl/fft_pkg.sv
// Shared FFT constants and the frame-capture state encoding.
// The FFT core and the capture sink both read their sizes from here.
package fft_pkg;

  localparam int N           = 1024;
  localparam int AW          = 10;
  localparam int DW          = 16;
  localparam int FFT_LATENCY = 10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    SKIP    = 3'd2,
    CAPTURE = 3'd3,
    FULL    = 3'd4
  } cap_state_e;

endpackage

// File: rtl/fft_frame_ram.sv
// Simple dual-port frame buffer: one write port and one registered read port.
// A read and a write to the same address in one cycle return the old word.
module fft_frame_ram #(
  parameter int DEPTH = fft_pkg::N,
  parameter int AW    = fft_pkg::AW,
  parameter int WW    = 2 * fft_pkg::DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [WW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [WW-1:0] rd_data
);

  logic [WW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Only the output register is reset, so the array still maps onto block RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_frame_capture.sv
// Stall-aware sink that skips the FFT pipeline latency and captures one
// N-point output frame into a buffer that the host reads by bin and releases.
//
// state   | meaning
// IDLE    | waiting for arm
// ARMED   | armed, waiting for the first enabled beat
// SKIP    | counting enabled beats through the FFT pipeline latency
// CAPTURE | writing one enabled beat per bin
// FULL    | frame complete, waiting for ack
module fft_frame_capture #(
  parameter int N       = fft_pkg::N,
  parameter int AW      = fft_pkg::AW,
  parameter int DW      = fft_pkg::DW,
  parameter int LATENCY = fft_pkg::FFT_LATENCY
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [DW-1:0] Xb_re,
  input  logic [DW-1:0] Xb_im,
  input  logic          arm,
  input  logic          ack,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_re,
  output logic [DW-1:0] rd_im,
  output logic          rd_valid,
  output logic          busy,
  output logic          frame_ready,
  output logic          overrun
);
  import fft_pkg::*;

  localparam int LW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  cap_state_e    state, state_nxt;
  logic [LW-1:0] lat_cnt, lat_nxt;
  logic [AW-1:0] wr_cnt, wr_nxt;
  logic          ovr_nxt;
  logic          we;
  logic [AW-1:0] wr_addr;
  logic [2*DW-1:0] rd_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      wr_cnt   <= '0;
      overrun  <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      lat_cnt  <= lat_nxt;
      wr_cnt   <= wr_nxt;
      overrun  <= ovr_nxt;
      rd_valid <= rd_en;
    end
  end

  always_comb begin
    state_nxt = state;
    lat_nxt   = lat_cnt;
    wr_nxt    = wr_cnt;
    ovr_nxt   = overrun;
    we        = 1'b0;
    wr_addr   = '0;
    case (state)
      IDLE: if (arm) state_nxt = ARMED;
      ARMED: if (enable) begin
        // With no pipeline latency the arming beat is already bin 0.
        if (LATENCY == 0) begin
          we        = 1'b1;
          wr_nxt    = AW'(1);
          state_nxt = CAPTURE;
        end else begin
          lat_nxt   = LW'(1);
          state_nxt = SKIP;
        end
      end
      SKIP: if (enable) begin
        if (lat_cnt == LW'(LATENCY)) begin
          we        = 1'b1;
          wr_nxt    = AW'(1);
          state_nxt = CAPTURE;
        end else begin
          lat_nxt = lat_cnt + LW'(1);
        end
      end
      CAPTURE: if (enable) begin
        we      = 1'b1;
        wr_addr = wr_cnt;
        wr_nxt  = wr_cnt + AW'(1);
        if (wr_cnt == AW'(N - 1)) state_nxt = FULL;
      end
      FULL: begin
        if (ack)      state_nxt = arm ? ARMED : IDLE;
        else if (arm) ovr_nxt   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy        = (state == ARMED) || (state == SKIP) || (state == CAPTURE);
  assign frame_ready = (state == FULL);

  fft_frame_ram #(
    .DEPTH (N),
    .AW    (AW),
    .WW    (2 * DW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data ({Xb_re, Xb_im}),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign rd_re = rd_data[2*DW-1:DW];
  assign rd_im = rd_data[DW-1:0];

endmodule

// File: tb/tb_fft_frame_capture.sv
// Directed bench for fft_frame_capture: one default-latency instance and one
// zero-latency instance sharing clock, reset, stream and read address.
module tb_fft_frame_capture;

  localparam int AW = fft_pkg::AW;
  localparam int DW = fft_pkg::DW;

  logic clk = 1'b0;
  logic rst, enable, arm, ack, arm0, ack0, rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] xb_re, xb_im;
  logic [DW-1:0] rd_re, rd_im, rd0_re, rd0_im;
  logic rd_valid, busy, frame_ready, overrun;
  logic rd0_valid, busy0, fr0, ovr0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fft_frame_capture dut (
    .clk(clk), .rst(rst), .enable(enable), .Xb_re(xb_re), .Xb_im(xb_im),
    .arm(arm), .ack(ack), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_re(rd_re), .rd_im(rd_im), .rd_valid(rd_valid), .busy(busy),
    .frame_ready(frame_ready), .overrun(overrun)
  );

  fft_frame_capture #(.LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .Xb_re(xb_re), .Xb_im(xb_im),
    .arm(arm0), .ack(ack0), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_re(rd0_re), .rd_im(rd0_im), .rd_valid(rd0_valid), .busy(busy0),
    .frame_ready(fr0), .overrun(ovr0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic en, input logic [DW-1:0] re, input logic [DW-1:0] im);
    enable = en;
    xb_re  = re;
    xb_im  = im;
    tick();
  endtask

  task automatic read_bin(input int a);
    rd_en   = 1'b1;
    rd_addr = AW'(a);
    tick();
    rd_en   = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; enable = 0; arm = 0; ack = 0; arm0 = 0; ack0 = 0;
    rd_en = 0; rd_addr = '0; xb_re = '0; xb_im = '0;
    tick(); tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (frame_ready !== 1'b0) begin n_fail++; $display("FAIL reset_fr: got %b want 0", frame_ready); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b want 0", overrun); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rdv: got %b want 0", rd_valid); end
    n_checks++; if ({rd_re, rd_im} !== 32'h0) begin n_fail++; $display("FAIL reset_rd: got %h want 0", {rd_re, rd_im}); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int ks[3] = '{0, 511, 1023};
    pulse_arm();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
    for (int i = 0; i < 1034; i++) begin
      beat(1'b1, DW'(i), DW'(-i));
      if (i == 1032) begin
        n_checks++; if (frame_ready !== 1'b0) begin n_fail++; $display("FAIL basic_fr_early: got %b want 0", frame_ready); end
      end
    end
    enable = 1'b0;
    n_checks++; if (frame_ready !== 1'b1) begin n_fail++; $display("FAIL basic_fr_rise: got %b want 1", frame_ready); end
    foreach (ks[j]) begin
      read_bin(ks[j]);
      n_checks++; if (rd_re !== DW'(10 + ks[j])) begin n_fail++; $display("FAIL basic_re[%0d]: got %0d want %0d", ks[j], rd_re, 10 + ks[j]); end
      n_checks++; if (rd_im !== DW'(-(10 + ks[j]))) begin n_fail++; $display("FAIL basic_im[%0d]: got %h want %h", ks[j], rd_im, DW'(-(10 + ks[j]))); end
      n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL basic_rdv[%0d]: got %b want 1", ks[j], rd_valid); end
    end
    tick();
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL basic_rdv_drop: got %b want 0", rd_valid); end
    n_checks++; if (rd_re !== DW'(1033)) begin n_fail++; $display("FAIL basic_rd_hold: got %0d want 1033", rd_re); end
  endtask

  task automatic test_ack_arm();
    ack = 1'b1; arm = 1'b1;
    tick();
    ack = 1'b0; arm = 1'b0;
    n_checks++; if (busy !== 1'b1 || frame_ready !== 1'b0) begin n_fail++; $display("FAIL ackarm_state: got busy=%b fr=%b want busy=1 fr=0", busy, frame_ready); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ackarm_ovr: got %b want 0", overrun); end
    for (int i = 0; i < 1034; i++) beat(1'b1, DW'(3 * i), DW'(i));
    enable = 1'b0;
    n_checks++; if (frame_ready !== 1'b1) begin n_fail++; $display("FAIL ackarm_fr: got %b want 1", frame_ready); end
    read_bin(0);
    n_checks++; if ({rd_re, rd_im} !== {DW'(30), DW'(10)}) begin n_fail++; $display("FAIL ackarm_bin0: got %h want %h", {rd_re, rd_im}, {DW'(30), DW'(10)}); end
    read_bin(1023);
    n_checks++; if ({rd_re, rd_im} !== {DW'(3 * 1033), DW'(1033)}) begin n_fail++; $display("FAIL ackarm_bin1023: got %h want %h", {rd_re, rd_im}, {DW'(3 * 1033), DW'(1033)}); end
  endtask

  task automatic test_stalls();
    int t = 0;
    int rise_t = -1;
    int ks[4] = '{0, 90, 511, 1023};
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_checks++; if (busy !== 1'b0 || frame_ready !== 1'b0) begin n_fail++; $display("FAIL stall_idle: got busy=%b fr=%b want 0 0", busy, frame_ready); end
    pulse_arm();
    for (int i = 0; i < 1034; i++) begin
      if (i > 0 && i % 100 == 0) begin
        for (int s = 0; s < 3; s++) begin
          beat(1'b0, 16'h7fff, 16'h7fff);
          t++;
          if (frame_ready && rise_t < 0) rise_t = t;
        end
      end
      beat(1'b1, DW'(i), DW'(-i));
      t++;
      if (frame_ready && rise_t < 0) rise_t = t;
    end
    enable = 1'b0;
    n_checks++; if (rise_t !== 1064) begin n_fail++; $display("FAIL stall_fr_time: got %0d want 1064", rise_t); end
    foreach (ks[j]) begin
      read_bin(ks[j]);
      n_checks++; if ({rd_re, rd_im} !== {DW'(10 + ks[j]), DW'(-(10 + ks[j]))}) begin
        n_fail++; $display("FAIL stall_bin[%0d]: got %h want %h", ks[j], {rd_re, rd_im}, {DW'(10 + ks[j]), DW'(-(10 + ks[j]))});
      end
    end
  endtask

  task automatic test_overrun();
    pulse_arm();
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", overrun); end
    n_checks++; if (frame_ready !== 1'b1) begin n_fail++; $display("FAIL ovr_keep_fr: got %b want 1", frame_ready); end
    read_bin(0);
    n_checks++; if (rd_re !== DW'(10)) begin n_fail++; $display("FAIL ovr_bin0: got %0d want 10", rd_re); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_checks++; if (frame_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL ovr_ack_idle: got fr=%b busy=%b want 0 0", frame_ready, busy); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_reset_mid();
    pulse_arm();
    rd_en = 1'b1;
    for (int i = 0; i < 500; i++) begin
      rd_addr = AW'(i);
      beat(1'b1, DW'(i), DW'(-i));
    end
    enable = 1'b1; xb_re = DW'(500); xb_im = DW'(-500);
    #2 rst = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || frame_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_state: got busy=%b fr=%b want 0 0", busy, frame_ready); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rdv: got %b want 0", rd_valid); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rstmid_ovr: got %b want 0", overrun); end
    rd_en = 1'b0; enable = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    pulse_arm();
    for (int i = 0; i < 1034; i++) beat(1'b1, DW'(i + 1000), ~DW'(i));
    enable = 1'b0;
    n_checks++; if (frame_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_fr: got %b want 1", frame_ready); end
    read_bin(0);
    n_checks++; if ({rd_re, rd_im} !== {DW'(1010), ~DW'(10)}) begin n_fail++; $display("FAIL rstmid_bin0: got %h want %h", {rd_re, rd_im}, {DW'(1010), ~DW'(10)}); end
    read_bin(1023);
    n_checks++; if ({rd_re, rd_im} !== {DW'(2033), ~DW'(1033)}) begin n_fail++; $display("FAIL rstmid_bin1023: got %h want %h", {rd_re, rd_im}, {DW'(2033), ~DW'(1033)}); end
  endtask

  task automatic test_lat0();
    arm0 = 1'b1;
    tick();
    arm0 = 1'b0;
    n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL lat0_busy: got %b want 1", busy0); end
    beat(1'b1, DW'(7), DW'(-7));
    beat(1'b1, DW'(8), DW'(-8));
    enable = 1'b0;
    read_bin(0);
    n_checks++; if ({rd0_re, rd0_im} !== {DW'(7), DW'(-7)}) begin n_fail++; $display("FAIL lat0_bin0: got %h want %h", {rd0_re, rd0_im}, {DW'(7), DW'(-7)}); end
    read_bin(1);
    n_checks++; if (rd0_re !== DW'(8)) begin n_fail++; $display("FAIL lat0_bin1: got %0d want 8", rd0_re); end
    n_checks++; if (fr0 !== 1'b0 || ovr0 !== 1'b0) begin n_fail++; $display("FAIL lat0_flags: got fr=%b ovr=%b want 0 0", fr0, ovr0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ack_arm();
    test_stalls();
    test_overrun();
    test_reset_mid();
    test_lat0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_frame_capture.md
Name: fft_frame_capture

Overview:
- Receive-side sink for the FFT streaming output (Xb_re/Xb_im).
- Tracks the same enable that drives the FFT core and skips the core's pipeline latency.
- Writes exactly one N-point output frame into an internal buffer and signals frame_ready; a host or readout logic then reads bins by address and releases the buffer with ack.
- Replaces bench-side "wait fixed time then sample" capture with a synthesizable, stall-aware block.

Parameters:
- N, 1024, points per frame; power of two.
- AW, 10, address width; log2(N).
- DW, 16, sample width, signed two's complement, per component.
- LATENCY, 10, enabled cycles from first enabled FFT input sample to first valid FFT output sample; 0 allowed.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  same enable that feeds the FFT core; a cycle with enable=1 is one stream beat.
- Xb_re  in  DW  FFT output, real part.
- Xb_im  in  DW  FFT output, imaginary part.
- arm  in  1  single-cycle request to capture the next frame.
- ack  in  1  single-cycle release of a captured frame.
- rd_en  in  1  read strobe.
- rd_addr  in  AW  bin index to read.
- rd_re  out  DW  read data, real part.
- rd_im  out  DW  read data, imaginary part.
- rd_valid  out  1  rd_re/rd_im valid.
- busy  out  1  high in ARMED, SKIP or CAPTURE.
- frame_ready  out  1  high in FULL.
- overrun  out  1  sticky error flag.

Behaviour:
- Reset (rst=0, async): state IDLE, counters 0; busy, frame_ready, overrun, rd_valid all 0; rd_re and rd_im 0. Buffer contents undefined.
- IDLE:
  - arm=1 -> ARMED.
  - ack ignored.
- ARMED:
  - On the first cycle with enable=1 -> SKIP, with lat_cnt=1.
  - If LATENCY=0, go straight to CAPTURE and that same beat is written as sample 0.
- SKIP:
  - Each enable=1 beat increments lat_cnt.
  - On the beat where lat_cnt==LATENCY, that beat is written to address 0 and the state becomes CAPTURE with wr_cnt=1.
  - Beats with enable=0 are stalls: no count, no write.
- CAPTURE:
  - Each enable=1 beat writes {Xb_re,Xb_im} to address wr_cnt, then wr_cnt increments.
  - The beat writing address N-1 moves the state to FULL. wr_cnt wraps to 0.
  - Stalls hold all state.
- FULL:
  - frame_ready=1 from the cycle after the last write.
  - Held until ack=1, which returns to IDLE the next cycle.
  - arm received in FULL (without ack) sets overrun=1; the frame is kept.
  - ack and arm together -> ARMED directly, no overrun.
- arm in ARMED, SKIP or CAPTURE: ignored, no overrun.
- Read port:
  - Reads are allowed in any state.
  - rd_en=1 at cycle t gives rd_re/rd_im/rd_valid at t+1 (synchronous RAM).
  - rd_valid is 0 on cycles after rd_en=0. rd_re/rd_im hold their last value.
  - Reading outside FULL returns stale or partial data; no error is raised.
  - A read and a write to the same address in one cycle returns the old data.
- overrun is cleared only by reset.
- Reset mid-capture: immediate return to IDLE. The partial frame is discarded and frame_ready=0.
- No arithmetic is applied to the data. Samples are stored bit-exact; width is 2*DW per word.

Decomposition:
- Shared package fft_pkg:
  - constants N, AW, DW, FFT_LATENCY (used by FFT_top and this block);
  - capture state encoding IDLE=0, ARMED=1, SKIP=2, CAPTURE=3, FULL=4 (3-bit).
- One sub-module fft_frame_ram: simple dual-port N x 2*DW RAM, one write port, one registered read port, inferrable as block RAM.
- The FSM, counters and flags stay in fft_frame_capture.

Test Plan:
- Basic capture:
  - Stimulus: arm, then 1034 continuous enable beats, with Xb_re = beat index and Xb_im = -(beat index).
  - Required: frame_ready rises one cycle after beat 1033; reading address k returns re=10+k, im=-(10+k) for k = 0, 511, 1023.
- Stalls:
  - Stimulus: same as basic capture, but enable is deasserted for 3 cycles every 100 beats.
  - Required: identical buffer contents; frame_ready is delayed by exactly the stall count.
- Overrun:
  - Stimulus: arm while FULL, without ack.
  - Required: overrun=1, data unchanged at address 0 (re=10); then ack returns the block to IDLE with frame_ready=0.
- Simultaneous ack and arm:
  - Stimulus: ack and arm in the same cycle while FULL.
  - Required: state ARMED next cycle, overrun stays 0, the next frame is captured correctly.
- LATENCY=0:
  - Stimulus: arm, then enable with Xb_re=7 on the first beat.
  - Required: address 0 holds re=7.
- Reset mid-capture:
  - Stimulus: rst low at beat 500.
  - Required: busy=0 and frame_ready=0 immediately; rd_valid=0. After release and re-arm, a full frame is captured correctly.
